// File: rtl/md_sched.sv
// Multi-cycle multiply/divide scheduler owning the HI/LO register pair.
// Results are computed from latched operands and committed on the final busy cycle.
module md_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MD_D,
    output logic        Busy,
    output logic        Stall_Req,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
    end

    // Signed divide runs on magnitudes; the overflow case falls out naturally
    // because -(0x80000000) wraps back to 0x80000000.
    always_comb begin
        div_signed = (op_q == 3'd2);
        a_neg      = div_signed & a_q[31];
        b_neg      = div_signed & b_q[31];
        mag_a      = a_neg ? (~a_q + 32'd1) : a_q;
        mag_b      = b_neg ? (~b_q + 32'd1) : b_q;
        uq         = '0;
        ur         = '0;
        if (b_q != '0) begin
            uq = mag_a / mag_b;
            ur = mag_a % mag_b;
        end
    end

    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        case (op_q)
            3'd0: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            3'd1: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            3'd2, 3'd3: begin
                if (b_q == '0) begin
                    res_hi = a_q;
                    res_lo = '1;
                end else begin
                    res_lo = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
                    res_hi = a_neg ? (~ur + 32'd1) : ur;
                end
            end
            default: begin
                res_hi = hi_q;
                res_lo = lo_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    case (Op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            a_d     = A;
                            b_d     = B;
                            op_d    = Op;
                            cnt_d   = (Op[1] == 1'b0) ? MULT_N : DIV_N;
                            state_d = RUN;
                        end
                        3'd4: hi_d = A;
                        3'd5: lo_d = A;
                        default: begin
                            state_d = state_q;
                        end
                    endcase
                end
            end
            RUN: begin
                // Start is deliberately not examined here, including on the commit edge.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy      = (state_q == RUN);
    assign Stall_Req = MD_D & (Start | Busy);
    assign HI        = hi_q;
    assign LO        = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed cases with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_md_sched;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  Op = 3'd6;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        MD_D = 1'b0;
    logic        Busy;
    logic        Stall_Req;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    md_sched #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Op       (Op),
        .A        (A),
        .B        (B),
        .MD_D     (MD_D),
        .Busy     (Busy),
        .Stall_Req(Stall_Req),
        .HI       (HI),
        .LO       (LO)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {HI, LO} for an arithmetic op, straight from the architectural rules.
    function automatic logic [63:0] calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      p;
        int          q;
        int          rm;
        logic [63:0] r;
        r = '0;
        case (op)
            3'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                r = p;
            end
            3'd1: r = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 0) r = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
                else begin
                    q  = $signed(a) / $signed(b);
                    rm = $signed(a) % $signed(b);
                    r  = {rm, q};
                end
            end
            3'd3: begin
                if (b == 0) r = {a, 32'hFFFFFFFF};
                else r = {a % b, a / b};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Behavioural model: remaining busy cycles plus the pending result.
    int          m_busy = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_res = '0;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_busy <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (m_busy > 0) begin
            if (m_busy == 1) begin
                m_hi <= m_res[63:32];
                m_lo <= m_res[31:0];
            end
            m_busy <= m_busy - 1;
        end else if (Start) begin
            if (Op <= 3'd3) begin
                m_busy <= (Op <= 3'd1) ? MULT_N : DIV_N;
                m_res  <= calc(Op, A, B);
            end else if (Op == 3'd4) begin
                m_hi <= A;
            end else if (Op == 3'd5) begin
                m_lo <= A;
            end
        end
    end

    always @(negedge Clk) begin
        chk("busy", {63'd0, Busy}, {63'd0, (m_busy > 0)});
        chk("stall", {63'd0, Stall_Req}, {63'd0, MD_D & (Start | (m_busy > 0))});
        chk("hi", {32'd0, HI}, {32'd0, m_hi});
        chk("lo", {32'd0, LO}, {32'd0, m_lo});
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge Clk); #1;
        Start = 1'b1; Op = op; A = a; B = b;
        @(posedge Clk); #1;
        Start = 1'b0; Op = 3'd6;
    endtask

    task automatic wait_idle(output int cycles);
        bit done;
        cycles = 0;
        done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (!Busy) begin
                done = 1;
                break;
            end
            cycles++;
        end
        if (!done) chk("wait_idle_timeout", 64'd1, 64'd0);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0;
            1: v = 32'h80000000;
            2: v = 32'hFFFFFFFF;
            3: v = $urandom_range(0, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int n;
        int sc;

        chk("model_mult", calc(3'd0, 32'hFFFFFFFE, 32'd3), {32'hFFFFFFFF, 32'hFFFFFFFA});
        chk("model_multu", calc(3'd1, 32'hFFFFFFFE, 32'd3), {32'h2, 32'hFFFFFFFA});
        chk("model_div", calc(3'd2, 32'hFFFFFFF9, 32'd2), {32'hFFFFFFFF, 32'hFFFFFFFD});
        chk("model_div_ovf", calc(3'd2, 32'h80000000, 32'hFFFFFFFF), {32'h0, 32'h80000000});

        MD_D = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk);
        chk("rst_busy", {63'd0, Busy}, 64'd0);
        chk("rst_hilo", {HI, LO}, 64'd0);
        chk("rst_stall", {63'd0, Stall_Req}, 64'd0);
        MD_D = 1'b0;

        issue(3'd0, 32'hFFFFFFFE, 32'd3);
        wait_idle(n);
        chk("mult_busy_cycles", 64'(n), 64'd5);
        chk("mult_result", {HI, LO}, {32'hFFFFFFFF, 32'hFFFFFFFA});

        issue(3'd1, 32'hFFFFFFFE, 32'd3);
        wait_idle(n);
        chk("multu_busy_cycles", 64'(n), 64'd5);
        chk("multu_result", {HI, LO}, {32'h2, 32'hFFFFFFFA});

        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        chk("div_busy_cycles", 64'(n), 64'd10);
        chk("div_result", {HI, LO}, {32'hFFFFFFFF, 32'hFFFFFFFD});

        issue(3'd3, 32'd7, 32'd0);
        wait_idle(n);
        chk("divu_zero_result", {HI, LO}, {32'd7, 32'hFFFFFFFF});

        // Stall window: Start cycle plus every busy cycle.
        @(posedge Clk); #1;
        MD_D = 1'b1; Start = 1'b1; Op = 3'd2; A = 32'hFFFFFFF9; B = 32'd2;
        @(negedge Clk);
        sc = (Stall_Req === 1'b1) ? 1 : 0;
        @(posedge Clk); #1;
        Start = 1'b0; Op = 3'd6;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (Stall_Req !== 1'b1) break;
            sc++;
        end
        chk("stall_cycles", 64'(sc), 64'd11);
        chk("stall_after", {63'd0, Stall_Req}, 64'd0);
        MD_D = 1'b0;

        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        repeat (3) @(posedge Clk);
        #1 Start = 1'b1; Op = 3'd5; A = 32'h1234;
        @(posedge Clk); #1 Start = 1'b0; Op = 3'd6;
        wait_idle(n);
        chk("mtlo_midrun_ignored", {32'd0, LO}, {32'd0, 32'hFFFFFFFD});

        issue(3'd4, 32'hDEADBEEF, 32'd0);
        @(negedge Clk);
        chk("mthi_busy", {63'd0, Busy}, 64'd0);
        chk("mthi_result", {HI, LO}, {32'hDEADBEEF, 32'hFFFFFFFD});

        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        chk("div_ovf_result", {HI, LO}, {32'h0, 32'h80000000});

        issue(3'd0, 32'd3, 32'd4);
        repeat (2) @(posedge Clk);
        #2 Reset = 1'b0;
        #1;
        chk("async_rst_busy", {63'd0, Busy}, 64'd0);
        chk("async_rst_hilo", {HI, LO}, 64'd0);
        @(posedge Clk); #1 Reset = 1'b1;
        issue(3'd0, 32'hFFFFFFFE, 32'd3);
        wait_idle(n);
        chk("post_rst_mult_cycles", 64'(n), 64'd5);
        chk("post_rst_mult", {HI, LO}, {32'hFFFFFFFF, 32'hFFFFFFFA});

        for (int i = 0; i < 3000; i++) begin
            @(posedge Clk); #1;
            Start = ($urandom_range(0, 2) == 0);
            Op    = 3'($urandom_range(0, 7));
            A     = pick();
            B     = pick();
            MD_D  = $urandom_range(0, 1) == 1;
        end
        @(posedge Clk); #1;
        Start = 1'b0; MD_D = 1'b0;
        repeat (20) @(posedge Clk);
        @(negedge Clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
